// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked shift, ACK check.
// Optional watchdog enabled by defining PS2TX_TIMEOUT_EN.
module ps2_tx #(
  parameter int INHIBIT_CLKS = 5000,
  parameter int SETUP_CLKS   = 16,
  parameter int FILTER       = 4,
  parameter int TIMEOUT_CLKS = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_send,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CW = $clog2(INHIBIT_CLKS + SETUP_CLKS + 1);
  localparam int FW = $clog2(FILTER + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAITIDLE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    n;
  logic [9:0]    sh;
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_i;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat_i;
      dat_s2 <= dat_s1;
    end
  end

  // A new clock level is accepted only after FILTER consecutive differing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
        fall     <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

`ifdef PS2TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CLKS + 1);
  logic [WW-1:0] wdog;
  logic          wd_active;

  assign wd_active = (state == SHIFT) || (state == ACK) || (state == WAITIDLE);
  assign timeout   = wd_active && !fall && (wdog == WW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      wdog <= '0;
    end else if (!wd_active || fall) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + WW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Main sequencer; every output is registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      n          <= '0;
      sh         <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (timeout) begin
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        tx_error   <= 1'b1;
        tx_busy    <= 1'b0;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (tx_send) begin
              sh         <= {1'b1, ~^tx_data, tx_data};
              ps2_clk_oe <= 1'b1;
              ps2_dat_oe <= 1'b0;
              cnt        <= '0;
              tx_busy    <= 1'b1;
              state      <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (cnt == CW'(INHIBIT_CLKS - 1)) begin
              ps2_dat_oe <= 1'b1;
              cnt        <= '0;
              state      <= RTS;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          RTS: begin
            if (cnt == CW'(SETUP_CLKS - 1)) begin
              ps2_clk_oe <= 1'b0;
              n          <= '0;
              cnt        <= '0;
              state      <= SHIFT;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          SHIFT: begin
            // The stop bit is a 1 in sh, so the tenth fall releases the data line.
            if (fall) begin
              ps2_dat_oe <= ~sh[0];
              sh         <= {1'b0, sh[9:1]};
              n          <= n + 4'd1;
              if (n == 4'd9) state <= ACK;
            end
          end
          ACK: begin
            if (fall) begin
              if (!dat_s2) begin
                state <= WAITIDLE;
              end else begin
                tx_error <= 1'b1;
                tx_busy  <= 1'b0;
                state    <= IDLE;
              end
            end
          end
          WAITIDLE: begin
            if (clk_filt && dat_s2) begin
              tx_done <= 1'b1;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_tx.md
# ps2_tx

Host-to-device PS/2 transmitter: sends one command byte to the keyboard, such as LED set (0xED) or reset (0xFF). It is the outbound side of the PS/2 port whose receiver already feeds `ps2_data`/`ps2_hit` into `portctl`. It sits between `portctl` and the open-drain PS2_CLK/PS2_DAT pins. It performs the clock inhibit, request-to-send, bit shifting on device clock edges, odd parity, stop bit and ACK check, with an optional watchdog.

## Interface
- `INHIBIT_CLKS`, 5000: clocks PS2_CLK is held low before request-to-send (100 µs @ 50 MHz).
- `SETUP_CLKS`, 16: clocks between asserting the start bit and releasing PS2_CLK.
- `FILTER`, 4: consecutive equal synchronized samples needed to accept a new ps2_clk level.
- `TIMEOUT_CLKS`, 750000: maximum clocks between device falling edges (15 ms @ 50 MHz). Used only with `PS2TX_TIMEOUT_EN`.
- `clock` in 1: single clock (clock50 domain). All logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `tx_data` in 8: byte to send. Sampled only on an accepted `tx_send`.
- `tx_send` in 1: one-cycle request. Accepted only when `tx_busy`=0.
- `tx_busy` out 1: high from the cycle after acceptance until the cycle of `tx_done`/`tx_error`. The receiver ignores bytes while this is high.
- `tx_done` out 1: one-cycle pulse when the device ACKs and the bus has returned idle.
- `tx_error` out 1: one-cycle pulse on NACK or timeout.
- `ps2_clk_i` in 1: raw PS2_CLK pin level. Asynchronous.
- `ps2_dat_i` in 1: raw PS2_DAT pin level. Asynchronous.
- `ps2_clk_oe` out 1: 1 = drive PS2_CLK low, 0 = release (Z).
- `ps2_dat_oe` out 1: 1 = drive PS2_DAT low, 0 = release (Z).

## Operation
- Input conditioning:
  - Each pin goes through a 2-FF synchronizer.
  - The clock line then goes through a FILTER-sample stable filter.
  - `fall` is a single-cycle pulse when the filtered clock goes 1→0.
- Shift register `sh[9:0]` = {1 (stop), ~^tx_data (odd parity), tx_data[7:0]}, loaded on accept. Bit counter `n` is 4 bits.
- States:
  - IDLE: both oe=0. On `tx_send` go to INHIBIT, set clk_oe=1, cnt=0.
  - INHIBIT: cnt++. At cnt==INHIBIT_CLKS-1 set dat_oe=1 (start bit), cnt=0, go to RTS.
  - RTS: cnt++. At cnt==SETUP_CLKS-1 set clk_oe=0, n=0, go to SHIFT.
  - SHIFT: on each `fall` set dat_oe = ~sh[0], shift sh right, n++.
    - Falls 1–8 present data LSB first, fall 9 presents parity, fall 10 presents stop (dat released).
    - After fall 10 go to ACK.
  - ACK: on `fall` sample synchronized dat. 0 → go to WAITIDLE. 1 → pulse `tx_error`, go to IDLE.
  - WAITIDLE: when filtered clk=1 and synchronized dat=1, pulse `tx_done` and go to IDLE.
- `tx_send` while busy is ignored. `tx_data` may change freely after acceptance.
- Reset in any state:
  - Next cycle: state IDLE, both oe=0, tx_busy=0.
  - No done or error pulse is generated.
  - Counters and shift register are cleared.
- Outputs never drive high. Only the oe outputs exist, and external tristates drive 0.

## Timing
- Reset values: tx_busy=0, tx_done=0, tx_error=0, ps2_clk_oe=0, ps2_dat_oe=0.
- Accept to clk_oe=1: 1 cycle.
- clk_oe low duration: exactly INHIBIT_CLKS+SETUP_CLKS cycles.
- Start bit (dat_oe=1) precedes clk release by SETUP_CLKS cycles.
- Pin falling edge to dat_oe update: 2 (sync) + FILTER + 1 cycles. This is far inside the device's half-period of about 30–50 µs.
- tx_done / tx_error are mutually exclusive and never coincide with a new accept. The earliest re-accept is the cycle after the pulse.

## Configuration
- `PS2TX_TIMEOUT_EN` defined:
  - A watchdog counts in SHIFT, ACK and WAITIDLE, and clears on every `fall`.
  - At TIMEOUT_CLKS it releases both lines, pulses `tx_error` and returns to IDLE.
- Undefined: no watchdog. A missing or silent device leaves the block in SHIFT/ACK/WAITIDLE until `reset`.

## Test plan
- Send 0xED with a device model clocking at 12 kHz and ACKing:
  - Observe the dat sequence after clk release: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop released.
  - ACK 0 → `tx_done` once, tx_busy falls the same cycle.
- Send 0x00 → parity bit 1. Send 0x01 → parity bit 0. Send 0xFF → parity bit 1. Each completes with `tx_done`.
- NACK: the device leaves dat high on the 11th clock → `tx_error` pulse, no `tx_done`, both oe=0.
- With `PS2TX_TIMEOUT_EN` and TIMEOUT_CLKS=100: the device stops after 4 clocks → `tx_error` exactly 100 cycles after the last fall. Without the macro, tx_busy stays 1.
- `tx_send` with 0x55 pulsed during a 0xF4 transfer is ignored: only 0xF4 bits appear and there is exactly one `tx_done`.
- `reset` asserted during SHIFT after 5 falls → the next cycle has both oe=0 and tx_busy=0, no pulses. A following send of 0xFF completes normally.
